// File: rtl/demux1_2_8b_reg.sv
// Registered 1-to-2 byte demultiplexer: one valid/ready input stream steered by sel
// into two independent output FIFOs, with per-port accepted-byte counters.
module demux1_2_8b_reg #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [7:0]       out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [7:0]       out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [7:0]       mem_q    [2][DEPTH];
  logic [7:0]       mem_d    [2][DEPTH];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    rd_ptr_d [2];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    wr_ptr_d [2];
  logic [PW:0]      fill_q   [2];
  logic [PW:0]      fill_d   [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];

  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  assign out_ready = {out1_ready, out0_ready};

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    full     = '0;
    push     = '0;
    pop      = '0;

    for (int i = 0; i < 2; i++) begin
      full[i] = (fill_q[i] == FULL_LVL);
    end

    // Readiness uses the pre-pop fill level, so a full FIFO never passes a byte through.
    in_ready = sel ? !full[1] : !full[0];
    push     = {in_valid && in_ready && sel, in_valid && in_ready && !sel};

    for (int i = 0; i < 2; i++) begin
      pop[i] = (fill_q[i] != '0) && out_ready[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data;
        wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
        cnt_d[i]              = cnt_q[i] + CNT_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
      fill_d[i] = fill_q[i] + {{PW{1'b0}}, push[i]} - {{PW{1'b0}}, pop[i]};
    end
  end

  // NOTE: non-blocking assignments for all state; the storage array is reset too, so outN_data reads 8'h00 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        fill_q[i]   <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out0_valid = (fill_q[0] != '0);
  assign out1_valid = (fill_q[1] != '0);
  assign out0_data  = mem_q[0][rd_ptr_q[0]];
  assign out1_data  = mem_q[1][rd_ptr_q[1]];
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_demux1_2_8b_reg.sv
// Self-checking bench for demux1_2_8b_reg: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the two FIFOs.
module tb_demux1_2_8b_reg;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             sel;
  logic             in_ready;
  logic [7:0]       out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [7:0]       out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  demux1_2_8b_reg #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .sel        (sel),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per port plus plain accepted-byte totals.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         acc0;
  int         acc1;
  bit         last_accept;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    acc0 = 0;
    acc1 = 0;
  endtask

  // Called at posedge+1; drives inputs, checks outputs at the negedge, then
  // advances the model over the next rising edge.
  task automatic step(input logic [7:0] d, input logic v, input logic s,
                      input logic r0, input logic r1);
    bit exp_ready;
    bit take0;
    bit take1;
    in_data    = d;
    in_valid   = v;
    sel        = s;
    out0_ready = r0;
    out1_ready = r1;
    @(negedge clk);
    exp_ready = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    check("in_ready",   32'(in_ready),   32'(exp_ready));
    check("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) check("out0_data", 32'(out0_data), 32'(q0[0]));
    if (q1.size() != 0) check("out1_data", 32'(out1_data), 32'(q1[0]));
    check("cnt0", 32'(cnt0), 32'(acc0 % 256));
    check("cnt1", 32'(cnt1), 32'(acc1 % 256));
    take0 = r0 && (q0.size() != 0);
    take1 = r1 && (q1.size() != 0);
    last_accept = v && exp_ready;
    @(posedge clk);
    if (take0) void'(q0.pop_front());
    if (take1) void'(q1.pop_front());
    if (last_accept) begin
      if (s) begin q1.push_back(d); acc1++; end
      else   begin q0.push_back(d); acc0++; end
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_v0"},  32'(out0_valid), 32'(0));
    check({tag, "_v1"},  32'(out1_valid), 32'(0));
    check({tag, "_d0"},  32'(out0_data),  32'(8'h00));
    check({tag, "_d1"},  32'(out1_data),  32'(8'h00));
    check({tag, "_c0"},  32'(cnt0),       32'(0));
    check({tag, "_c1"},  32'(cnt1),       32'(0));
    check({tag, "_rdy"}, 32'(in_ready),   32'(1));
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("reset");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; in_data = '0; in_valid = 1'b0; sel = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Single byte to port 0, popped the cycle after it appears.
    step(8'hA5, 1, 0, 1, 1);
    check("a5_valid", 32'(out0_valid), 32'(1));
    check("a5_data",  32'(out0_data),  32'(8'hA5));
    step(8'h00, 0, 0, 1, 1);
    step(8'h00, 0, 0, 1, 1);
    check("a5_cnt0", 32'(cnt0), 32'(1));
    check("a5_cnt1", 32'(cnt1), 32'(0));

    // Port 1 stalled: fills after two bytes, port 0 still flows.
    step(8'h11, 1, 1, 1, 0);
    step(8'h22, 1, 1, 1, 0);
    step(8'h33, 1, 1, 1, 0);
    check("p1_full_blocks", 32'(last_accept), 32'(0));
    step(8'h44, 1, 0, 1, 0);
    check("p0_accept_44", 32'(last_accept), 32'(1));
    step(8'h00, 0, 0, 1, 0);
    step(8'h00, 0, 0, 1, 1);
    step(8'h00, 0, 0, 1, 1);
    step(8'h00, 0, 0, 1, 1);

    // Full FIFO 0 refuses a push in the cycle it is popped.
    step(8'hB1, 1, 0, 0, 1);
    step(8'hB2, 1, 0, 0, 1);
    step(8'h55, 1, 0, 1, 1);
    check("full_pop_no_pass", 32'(last_accept), 32'(0));
    step(8'h55, 1, 0, 1, 1);
    check("full_pop_next", 32'(last_accept), 32'(1));
    step(8'h00, 0, 0, 1, 1);
    step(8'h00, 0, 0, 1, 1);
    step(8'h00, 0, 0, 1, 1);

    // Streaming 0x00..0x0F alternating sel, no bubbles.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(8'(i), 1, 1'(i % 2), 1, 1);
      check("stream_accept", 32'(last_accept), 32'(1));
    end
    step(8'h00, 0, 0, 1, 1);
    step(8'h00, 0, 0, 1, 1);
    check("stream_cnt0", 32'(cnt0), 32'(8));
    check("stream_cnt1", 32'(cnt1), 32'(8));

    // Counter wrap after 257 bytes into port 1.
    do_reset();
    for (int i = 0; i < 257; i++) step(8'(i * 3), 1, 1, 1, 1);
    step(8'h00, 0, 0, 1, 1);
    check("wrap_cnt1", 32'(cnt1), 32'(1));
    check("wrap_cnt0", 32'(cnt0), 32'(0));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end

    // Mid-stream reset with both FIFOs holding bytes.
    step(8'hC0, 1, 0, 0, 0);
    step(8'hC1, 1, 1, 0, 0);
    check("pre_rst_v0", 32'(out0_valid), 32'(1));
    check("pre_rst_v1", 32'(out1_valid), 32'(1));
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(8'h7E, 1, 1, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    check("fresh_v1", 32'(out1_valid), 32'(1));
    check("fresh_d1", 32'(out1_data),  32'(8'h7E));
    check("fresh_v0", 32'(out0_valid), 32'(0));
    step(8'h00, 0, 0, 0, 1);
    step(8'h00, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1_2_8b_reg.md
# demux1_2_8b_reg

Registered 1-to-2 byte demultiplexer: the receive-side counterpart of the team's 8-bit 2:1 mux. A single 8-bit valid/ready input stream is steered to one of two output streams by `sel`. Each output has its own small FIFO, so one stalled consumer does not block bytes steered to the other. It sits after a shared byte channel and feeds the two consumers that the 2:1 mux datapath merges upstream.

## Interface
- `DEPTH`, 2: entries per output FIFO; power of 2, ≥2.
- `CNT_W`, 8: width of the per-port accepted-byte counters.

- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: input byte.
- `in_valid` in 1: `in_data`/`sel` valid this cycle.
- `sel` in 1: destination, 0 → port 0, 1 → port 1. Sampled together with `in_data`.
- `in_ready` out 1: the selected FIFO can accept a byte.
- `out0_data` out 8: head byte of FIFO 0.
- `out0_valid` out 1: FIFO 0 not empty.
- `out0_ready` in 1: port 0 consumer accepts the head byte.
- `out1_data`, `out1_valid`, `out1_ready`: same as port 0, for FIFO 1.
- `cnt0` out CNT_W: bytes accepted into FIFO 0 since reset, modulo 2^CNT_W.
- `cnt1` out CNT_W: the same for FIFO 1.

## Operation
- Push: on a rising edge with `in_valid && in_ready`, `in_data` is written to the tail of FIFO[`sel`], and cnt[`sel`] increments.
- `in_ready` is combinational: `sel ? !full1 : !full0`. It is based on the fill level before the current cycle's pop; a full FIFO never accepts a byte in the cycle it is popped (no pass-through).
- Pop: on a rising edge with `outN_valid && outN_ready`, the FIFO N head advances. `outN_ready` while `outN_valid`=0 has no effect.
- A push and a pop on the same FIFO in the same cycle is legal when not full. The fill level is unchanged and data order is preserved.
- Pops on both ports plus a push to either port may all occur in the same cycle.
- Each FIFO has:
  - read and write pointers, each log2(DEPTH) bits, that wrap modulo DEPTH;
  - a fill counter of log2(DEPTH)+1 bits;
  - full = (fill == DEPTH), empty = (fill == 0).
- `outN_data` = storage[rd_ptrN], driven combinationally from registers. The value is don't-care while `outN_valid`=0, except after reset.
- The counters wrap from 2^CNT_W−1 to 0. Bytes are counted at acceptance, not at output.
- When `in_valid`=0, `sel` and `in_data` are ignored. `in_ready` still reflects the currently selected FIFO.
- Reset (`rst_n`=0, any time, including mid-transfer) asynchronously:
  - clears all pointers, fill counters and storage;
  - forces `out0_valid`=`out1_valid`=0, `out0_data`=`out1_data`=8'h00 and `cnt0`=`cnt1`=0;
  - leaves `in_ready`=1, because both FIFOs are empty.

  Bytes in flight are discarded. The first edge after `rst_n` rises operates normally.

## Timing
- Latency: a byte pushed at edge N is visible with `outN_valid`=1 in the cycle after edge N. The earliest pop is at edge N+1, so the minimum latency is 1 cycle.
- Throughput: 1 byte/cycle in, and up to 1 byte/cycle out per port, sustained with no bubble while neither FIFO is full.
- The `in_ready` → `in_valid` path has no combinational loop. `in_ready` depends only on `sel` and registered state.
- `outN_valid` and `outN_data` are registered or decoded from registers only. There is no combinational path from the input to the outputs.

## Test plan
- Reset, then push 8'hA5 with sel=0 and both readies=1 → `out0_valid`=1, `out0_data`=8'hA5 the next cycle, popped the cycle after; `cnt0`=1, `cnt1`=0, `out1_valid` never asserted.
- Hold `out1_ready`=0, push 8'h11, 8'h22, 8'h33 with sel=1 (DEPTH=2) → first two accepted; `in_ready`=0 on the third while sel=1. Switch sel=0 and push 8'h44 → accepted and delivered on port 0 while port 1 stays full. Release `out1_ready` → 8'h11, 8'h22 in order.
- FIFO 0 full, with a pop and a push of 8'h55 offered in the same cycle → `in_ready`=0, push not taken; the next cycle, push accepted.
- Streaming 1 byte/cycle, alternating sel, both readies=1, with 8'h00..8'h0F → port 0 receives the even values and port 1 the odd values, no bubbles; `cnt0`=`cnt1`=8.
- Push 257 bytes to port 1 with CNT_W=8 → `cnt1`=1 (wrap).
- Assert `rst_n`=0 mid-stream with both FIFOs non-empty → in the same cycle: all valids=0, data=8'h00, counts=0, `in_ready`=1. After release, a fresh push of 8'h7E appears alone on its port.
